if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h4000_0000, meaning the first fetch address after reset (BIOS base).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port ex_flush, input, 1, EX-resolved misprediction redirect.
REQ-005 The block SHALL have port ex_pc_target, input, 32, the correct PC when ex_flush=1.
REQ-006 The block SHALL have port id_stall, input, 1, the ID hazard stall that holds the fetch.
REQ-007 The block SHALL have port if_pc_target, input, 32, the ID predictor/target-generator address.
REQ-008 The block SHALL have port if_target_taken, input, 1, a flag to use if_pc_target.
REQ-009 The block SHALL have port bios_addra, output, 12, the BIOS word address, fetch_pc[13:2].
REQ-010 The block SHALL have port imem_addrb, output, 14, the IMEM word address, fetch_pc[15:2].
REQ-011 The block SHALL have port id_pc, output, 32, the registered PC of the instruction now on the memory outputs.
REQ-012 The block SHALL have port fetch_cnt, output, 32, the count of accepted fetches.
REQ-013 The block SHALL have port redirect_cnt, output, 32, the count of ex_flush redirects.

Function
REQ-014 The block SHALL compute fetch_pc combinationally, using the first matching priority: rst -> RESET_PC; ex_flush -> ex_pc_target; id_stall -> id_pc; if_target_taken -> if_pc_target; otherwise id_pc+4.
REQ-015 The block SHALL force fetch_pc[1:0] to 2'b00 in every case.
REQ-016 The block SHALL drive both bios_addra and imem_addrb from fetch_pc every cycle; the ID-side selection on id_pc[30] picks BIOS (1) or IMEM (0).
REQ-017 The block SHALL register id_pc <= fetch_pc on every clock edge, giving one-cycle latency that matches the synchronous-read memories, so the instruction and id_pc arrive in ID together.
REQ-018 While id_stall=1 and ex_flush=0, the block SHALL keep id_pc and the memory addresses unchanged, so the memory outputs stay stable for ID.
REQ-019 The block SHALL give ex_flush priority over id_stall; the wrong-path instruction in ID is discarded by ID's own flush reset.
REQ-020 The block SHALL ignore if_target_taken while id_stall=1, because the target may depend on unresolved forwarding.
REQ-021 The block SHALL add no bubble on an ID redirect: the target instruction is in ID on the cycle after if_target_taken.
REQ-022 The block SHALL add no extra bubble on an EX redirect: the target is in ID on the cycle after ex_flush.
REQ-023 The block SHALL compute id_pc+4 modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000, with no error.
REQ-024 The block SHALL increment fetch_cnt by 1 on each edge with rst=0 and (id_stall=0 or ex_flush=1); it wraps at 2^32.
REQ-025 The block SHALL increment redirect_cnt by 1 on each edge with rst=0 and ex_flush=1; it wraps at 2^32.
REQ-026 The block SHALL, when ex_flush and if_target_taken are both 1, use ex_pc_target.
REQ-027 The block SHALL, when ex_flush and id_stall are both 1, use ex_pc_target and increment fetch_cnt.

Reset
REQ-028 The block SHALL, on rst=1 at a clock edge, set id_pc=RESET_PC, fetch_cnt=0 and redirect_cnt=0.
REQ-029 The block SHALL drive bios_addra=RESET_PC[13:2] during reset, so the first post-reset cycle shows the instruction at RESET_PC with id_pc=RESET_PC.
REQ-030 The block SHALL let rst asserted mid-stall or mid-redirect override all other inputs on that edge.
REQ-031 The block SHALL contain no state other than id_pc and the two counters.

Verification
REQ-032 The bench SHALL drive a reset pulse, then 3 idle cycles -> id_pc = 4000_0000, 4000_0004, 4000_0008, 4000_000C; fetch_cnt=3.
REQ-033 The bench SHALL, with id_pc=4000_0010, drive if_target_taken=1 and if_pc_target=1000_0000 -> next id_pc=1000_0000 and imem_addrb=0 on the same cycle.
REQ-034 The bench SHALL, with id_pc=1000_0020, drive id_stall=1 for 2 cycles and if_target_taken=1 -> id_pc holds 1000_0020 and fetch_cnt is unchanged; after release id_pc=1000_0024.
REQ-035 The bench SHALL drive ex_flush=1, id_stall=1, if_target_taken=1, ex_pc_target=1000_0103 -> id_pc=1000_0100 and redirect_cnt +1.
REQ-036 The bench SHALL, with id_pc=FFFF_FFFC and no stall, advance one cycle -> id_pc=0000_0000.
REQ-037 The bench SHALL assert rst during id_stall=1 with id_pc=1000_0040 -> id_pc=4000_0000 and both counters 0.

Source files
------------

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: redirect/stall inputs from ID/EX, memory addresses and PC/counters out.
interface if_stage_if;
  logic        ex_flush;
  logic [31:0] ex_pc_target;
  logic        id_stall;
  logic [31:0] if_pc_target;
  logic        if_target_taken;
  logic [11:0] bios_addra;
  logic [13:0] imem_addrb;
  logic [31:0] id_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  // ID/EX side drives control, observes addresses and PC
  modport master (
    output ex_flush, ex_pc_target, id_stall, if_pc_target, if_target_taken,
    input  bios_addra, imem_addrb, id_pc, fetch_cnt, redirect_cnt
  );

  modport slave (
    input  ex_flush, ex_pc_target, id_stall, if_pc_target, if_target_taken,
    output bios_addra, imem_addrb, id_pc, fetch_cnt, redirect_cnt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch PC select: 1-cycle latency (id_pc tracks sync-read memories);
// an ID stall holds PC and addresses, an EX flush overrides the stall.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.slave  bus
);

  logic [31:0] id_pc_q,        id_pc_d;
  logic [31:0] fetch_cnt_q,    fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] pc_sel;
  logic [31:0] fetch_pc;
  logic        fetch_acc;

  // Priority: reset, EX redirect, stall hold, ID redirect, sequential
  always_comb begin
    pc_sel = id_pc_q + 32'd4;
    if (rst)
      pc_sel = RESET_PC;
    else if (bus.ex_flush)
      pc_sel = bus.ex_pc_target;
    else if (bus.id_stall)
      pc_sel = id_pc_q;
    else if (bus.if_target_taken)
      pc_sel = bus.if_pc_target;
    fetch_pc = {pc_sel[31:2], 2'b00};
  end

  assign fetch_acc = !bus.id_stall || bus.ex_flush;

  always_comb begin
    id_pc_d        = fetch_pc;
    fetch_cnt_d    = fetch_acc    ? fetch_cnt_q + 32'd1    : fetch_cnt_q;
    redirect_cnt_d = bus.ex_flush ? redirect_cnt_q + 32'd1 : redirect_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q        <= RESET_PC;
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      id_pc_q        <= id_pc_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Both memories see the same fetch address; ID picks one by id_pc[30]
  assign bus.bios_addra   = fetch_pc[13:2];
  assign bus.imem_addrb   = fetch_pc[15:2];
  assign bus.id_pc        = id_pc_q;
  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, ID/EX redirects, stall, wrap, reset-in-stall.
module tb_if_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h4000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_flush        = 1'b0;
    bus.ex_pc_target    = 32'h0;
    bus.id_stall        = 1'b0;
    bus.if_pc_target    = 32'h0;
    bus.if_target_taken = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_bios_addr", {20'd0, bus.bios_addra}, 32'h0);
    check("rst_imem_addr", {18'd0, bus.imem_addrb}, 32'h0);
    step();
    check("rst_id_pc",     bus.id_pc,        32'h4000_0000);
    check("rst_fetch_cnt", bus.fetch_cnt,    32'd0);
    check("rst_redir_cnt", bus.redirect_cnt, 32'd0);

    rst = 1'b0;
    step(); check("seq_pc1", bus.id_pc, 32'h4000_0004);
    step(); check("seq_pc2", bus.id_pc, 32'h4000_0008);
    step(); check("seq_pc3", bus.id_pc, 32'h4000_000C);
    check("seq_fetch_cnt", bus.fetch_cnt, 32'd3);
    step(); check("seq_pc4", bus.id_pc, 32'h4000_0010);

    // ID redirect: address visible same cycle, target in ID next cycle
    bus.if_target_taken = 1'b1;
    bus.if_pc_target    = 32'h1000_0000;
    #1;
    check("idr_imem_addr", {18'd0, bus.imem_addrb}, 32'h0);
    step();
    check("idr_id_pc",     bus.id_pc,     32'h1000_0000);
    check("idr_fetch_cnt", bus.fetch_cnt, 32'd5);

    bus.if_pc_target = 32'h1000_0022;
    #1;
    check("idr2_imem_addr", {18'd0, bus.imem_addrb}, 32'h8);
    step();
    check("idr2_id_pc", bus.id_pc, 32'h1000_0020);

    // Stall with a pending ID target: everything holds
    bus.id_stall     = 1'b1;
    bus.if_pc_target = 32'h1000_0080;
    #1;
    check("stall_imem_addr", {18'd0, bus.imem_addrb}, 32'h8);
    step();
    check("stall1_id_pc",     bus.id_pc,     32'h1000_0020);
    check("stall1_fetch_cnt", bus.fetch_cnt, 32'd6);
    step();
    check("stall2_id_pc",     bus.id_pc,     32'h1000_0020);
    check("stall2_fetch_cnt", bus.fetch_cnt, 32'd6);
    idle_inputs();
    step();
    check("unstall_id_pc",     bus.id_pc,     32'h1000_0024);
    check("unstall_fetch_cnt", bus.fetch_cnt, 32'd7);

    // EX flush beats stall and ID target; low bits forced to zero
    bus.ex_flush        = 1'b1;
    bus.id_stall        = 1'b1;
    bus.if_target_taken = 1'b1;
    bus.if_pc_target    = 32'h2000_0000;
    bus.ex_pc_target    = 32'h1000_0103;
    #1;
    check("flush_imem_addr", {18'd0, bus.imem_addrb}, 32'h40);
    step();
    check("flush_id_pc",     bus.id_pc,        32'h1000_0100);
    check("flush_redir_cnt", bus.redirect_cnt, 32'd1);
    check("flush_fetch_cnt", bus.fetch_cnt,    32'd8);

    // Flush vs ID target without stall, landing at the top of the address space
    bus.id_stall     = 1'b0;
    bus.ex_pc_target = 32'hFFFF_FFFC;
    #1;
    check("flush2_bios_addr", {20'd0, bus.bios_addra}, 32'hFFF);
    check("flush2_imem_addr", {18'd0, bus.imem_addrb}, 32'h3FFF);
    step();
    check("flush2_id_pc",     bus.id_pc,        32'hFFFF_FFFC);
    check("flush2_redir_cnt", bus.redirect_cnt, 32'd2);
    idle_inputs();
    step();
    check("wrap_id_pc",     bus.id_pc,        32'h0000_0000);
    check("wrap_fetch_cnt", bus.fetch_cnt,    32'd10);
    check("wrap_redir_cnt", bus.redirect_cnt, 32'd2);

    // Reset during a stall overrides everything
    bus.if_target_taken = 1'b1;
    bus.if_pc_target    = 32'h1000_0040;
    step();
    check("pre_rst_id_pc", bus.id_pc, 32'h1000_0040);
    idle_inputs();
    bus.id_stall = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_stall_imem_addr", {18'd0, bus.imem_addrb}, 32'h0);
    step();
    check("rst_stall_id_pc",     bus.id_pc,        32'h4000_0000);
    check("rst_stall_fetch_cnt", bus.fetch_cnt,    32'd0);
    check("rst_stall_redir_cnt", bus.redirect_cnt, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_hold_pc", bus.id_pc,     32'h4000_0000);
    check("post_rst_hold_fc", bus.fetch_cnt, 32'd0);
    bus.id_stall = 1'b0;
    step();
    check("post_rst_pc", bus.id_pc,     32'h4000_0004);
    check("post_rst_fc", bus.fetch_cnt, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
